// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared segment patterns and nibble-to-segment lookup for display blocks.
// Bit order of every pattern is {a,b,c,d,e,f,g}.
package seven_seg_scan_driver_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;

    // Letters 10-15 only appear in hex mode; otherwise those codes show nothing.
    function automatic logic [6:0] seg_pattern(input logic [3:0] nib, input logic hex_mode);
        logic [6:0] hex;
        hex = SEG_BLANK;
        case (nib)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: hex = SEG_A;
            4'hB: hex = SEG_B;
            4'hC: hex = SEG_C;
            4'hD: hex = SEG_D;
            4'hE: hex = SEG_E;
            default: hex = SEG_F;
        endcase
        return hex_mode ? hex : SEG_BLANK;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_decoder.sv
// Combinational nibble -> 7-segment pattern, active-high segments.
import seven_seg_scan_driver_pkg::*;

module seven_seg_scan_driver_decoder (
    input  logic [3:0] nib,
    input  logic       hex_mode,
    output logic [6:0] pattern
);

    assign pattern = seg_pattern(nib, hex_mode);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with tear-free frame updates,
// leading-zero blanking, per-digit decimal points and output polarity select.
import seven_seg_scan_driver_pkg::*;

module seven_seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int HEX_MODE   = 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [PW-1:0]                presc;
    logic [IW-1:0]                idx;
    logic                         tc;
    logic                         wrap;

    logic [NUM_DIGITS-1:0][3:0]   pend_val;
    logic [NUM_DIGITS-1:0]        pend_dp;
    logic                         pend_valid;
    logic [NUM_DIGITS-1:0][3:0]   disp_val;
    logic [NUM_DIGITS-1:0]        disp_dp;

    logic [NUM_DIGITS-1:0]        lz_mask;
    logic                         lz_run;
    logic [3:0]                   cur_nib;
    logic [6:0]                   cur_pat;
    logic [NUM_DIGITS-1:0]        sel;

    assign tc   = (presc == PW'(PRESCALE - 1));
    assign wrap = tc && (idx == IW'(NUM_DIGITS - 1));

    // Slot timing: prescaler counts out each digit slot, digit index steps on terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (tc) begin
            presc <= '0;
            idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Double-buffered data: loads land in pending, display only changes at frame wrap.
    // A load coinciding with the wrap is the newest data, so it goes straight to display.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
        end else if (wrap && load) begin
            pend_val   <= value;
            pend_dp    <= dp_in;
            pend_valid <= 1'b0;
            disp_val   <= value;
            disp_dp    <= dp_in;
        end else begin
            if (load) begin
                pend_val   <= value;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end
            if (wrap && pend_valid) begin
                disp_val   <= pend_val;
                disp_dp    <= pend_dp;
                pend_valid <= 1'b0;
            end
        end
    end

    // Leading-zero mask: walk down from the MSB while nibbles stay zero; digit 0 never blanks.
    always_comb begin
        lz_mask = '0;
        lz_run  = blank_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run     = lz_run && (disp_val[i] == 4'h0);
            lz_mask[i] = lz_run;
        end
    end

    assign cur_nib = disp_val[idx];
    assign sel     = (NUM_DIGITS)'(1) << idx;

    seven_seg_scan_driver_decoder u_dec (
        .nib      (cur_nib),
        .hex_mode (HEX_MODE != 0),
        .pattern  (cur_pat)
    );

    // Output registers: one cycle behind slot state; anodes off in slot cycle 0 to avoid ghosting.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= {7{POL}};
            dp         <= POL;
            an         <= {NUM_DIGITS{POL}};
            frame_done <= 1'b0;
        end else begin
            seg        <= (lz_mask[idx] ? SEG_BLANK : cur_pat) ^ {7{POL}};
            dp         <= disp_dp[idx] ^ POL;
            an         <= ((presc == '0) ? '0 : sel) ^ {NUM_DIGITS{POL}};
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench: dut uses HEX_MODE=1/ACTIVE_LOW=0, dut2 shares stimulus with
// HEX_MODE=0/ACTIVE_LOW=1 so both decode modes and polarities are seen together.
module tb_seven_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg, seg2;
    logic        dp, dp2;
    logic [3:0]  an, an2;
    logic        frame_done, fd2;

    int total = 0;
    int bad   = 0;

    seven_seg_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .HEX_MODE(1), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    seven_seg_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .HEX_MODE(0), .ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(seg2), .dp(dp2), .an(an2), .frame_done(fd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("wait_fd", {31'd0, frame_done}, 32'd1);
    endtask

    // Call with frame_done just seen high; checks all 16 cycles of the next frame.
    task automatic scan(input string tag, input logic [3:0][6:0] es,
                        input logic [3:0][6:0] es2, input logic [3:0] edp);
        logic [3:0] oh;
        for (int d = 0; d < 4; d++) begin
            oh = 4'b0001 << d;
            tick();
            chk({tag, "_guard_an"},  {28'd0, an},  32'h0);
            chk({tag, "_guard_an2"}, {28'd0, an2}, 32'hF);
            chk({tag, "_fd_low"},    {31'd0, frame_done}, 32'd0);
            for (int k = 1; k < 4; k++) begin
                tick();
                chk({tag, "_an"},   {28'd0, an},   {28'd0, oh});
                chk({tag, "_seg"},  {25'd0, seg},  {25'd0, es[d]});
                chk({tag, "_dp"},   {31'd0, dp},   {31'd0, edp[d]});
                chk({tag, "_an2"},  {28'd0, an2},  {28'd0, ~oh});
                chk({tag, "_seg2"}, {25'd0, seg2}, {25'd0, ~es2[d]});
                chk({tag, "_dp2"},  {31'd0, dp2},  {31'd0, ~edp[d]});
            end
        end
        chk({tag, "_fd"},  {31'd0, frame_done}, 32'd1);
        chk({tag, "_fd2"}, {31'd0, fd2},        32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value    = '0;
        dp_in    = '0;
        blank_lz = 1'b0;

        // 1. reset state, first anode 2 cycles after release
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_seg", {25'd0, seg}, 32'h00);
            chk("rst_an",  {28'd0, an},  32'h0);
            chk("rst_dp",  {31'd0, dp},  32'h0);
            chk("rst_fd",  {31'd0, frame_done}, 32'h0);
            chk("rst_seg2", {25'd0, seg2}, 32'h7F);
            chk("rst_an2",  {28'd0, an2},  32'hF);
            chk("rst_dp2",  {31'd0, dp2},  32'h1);
        end
        rst = 1'b0;
        tick();
        chk("rel1_an", {28'd0, an}, 32'h0);
        chk("rel1_fd", {31'd0, frame_done}, 32'h0);
        tick();
        chk("rel2_an",  {28'd0, an},  32'h1);
        chk("rel2_seg", {25'd0, seg}, 32'h7E);

        // 2. hex digits and frame cadence
        do_load(16'h12AF, 4'b0000);
        wait_fd();
        scan("hex", {7'h30, 7'h6D, 7'h77, 7'h47}, {7'h30, 7'h6D, 7'h00, 7'h00}, 4'b0000);

        // 3. leading-zero blanking, dp survives on a blanked digit
        blank_lz = 1'b1;
        do_load(16'h0042, 4'b0100);
        wait_fd();
        scan("lz42", {7'h00, 7'h00, 7'h33, 7'h6D}, {7'h00, 7'h00, 7'h33, 7'h6D}, 4'b0100);
        do_load(16'h0000, 4'b0000);
        wait_fd();
        scan("lz0", {7'h00, 7'h00, 7'h00, 7'h7E}, {7'h00, 7'h00, 7'h00, 7'h7E}, 4'b0000);

        // 4. two loads inside one frame: old data until wrap, last load wins
        blank_lz = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        do_load(16'h1111, 4'b0000);
        for (int i = 0; i < 3; i++) tick();
        do_load(16'h2222, 4'b0000);
        chk("mid_an",  {28'd0, an},  32'h4);
        chk("mid_seg", {25'd0, seg}, 32'h7E);
        wait_fd();
        scan("last", {7'h6D, 7'h6D, 7'h6D, 7'h6D}, {7'h6D, 7'h6D, 7'h6D, 7'h6D}, 4'b0000);

        // 5. decimal digits vs hex-off blanking
        do_load(16'hBA98, 4'b0000);
        wait_fd();
        scan("hexoff", {7'h1F, 7'h77, 7'h7B, 7'h7F}, {7'h00, 7'h00, 7'h7B, 7'h7F}, 4'b0000);

        // 6. load on the wrap edge goes straight to display
        for (int i = 0; i < 15; i++) tick();
        do_load(16'h3456, 4'b0000);
        chk("wrapld_fd", {31'd0, frame_done}, 32'd1);
        scan("wrapld", {7'h79, 7'h33, 7'h5B, 7'h5F}, {7'h79, 7'h33, 7'h5B, 7'h5F}, 4'b0000);

        // reset mid-frame discards pending data
        for (int i = 0; i < 3; i++) tick();
        do_load(16'h7777, 4'b1111);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_an",   {28'd0, an},   32'h0);
        chk("mrst_seg",  {25'd0, seg},  32'h00);
        chk("mrst_dp",   {31'd0, dp},   32'h0);
        chk("mrst_an2",  {28'd0, an2},  32'hF);
        chk("mrst_seg2", {25'd0, seg2}, 32'h7F);
        rst = 1'b0;
        tick();
        chk("mrel1_an", {28'd0, an}, 32'h0);
        tick();
        chk("mrel2_an", {28'd0, an}, 32'h1);
        wait_fd();
        scan("postrst", {7'h7E, 7'h7E, 7'h7E, 7'h7E}, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
